// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: one bus request/acknowledge transaction per access, with lane alignment and load extension.
// Optional: define LSU_TIMEOUT_EN to abort a REQ that waits TIMEOUT_CYCLES cycles without bus_ack.
module lsu_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       ld_data,
  output logic              ld_valid,
  output logic              lsu_fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("lsu_ctrl: TIMEOUT_CYCLES must be >= 1");
  end

  state_e            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;

  logic              illegal, misaligned;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [31:0]       lane, ld_ext;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timed_out;

  assign cnt_d     = (state_q == REQ) ? cnt_q + 1'b1 : '0;
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  // Legality and alignment are judged on the live inputs, only consumed in IDLE.
  always_comb begin
    illegal = 1'b0;
    if (mem_read && mem_write)
      illegal = 1'b1;
    else if (mem_read)
      illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    else if (mem_write)
      illegal = funct3[2] || (funct3[1:0] == 2'b11);

    misaligned = 1'b0;
    if (funct3[1:0] == 2'b01)
      misaligned = addr[0];
    else if (funct3[1:0] == 2'b10)
      misaligned = (addr[1:0] != 2'b00);
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr[1:0];
        st_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << {addr[1], 1'b0};
        st_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane = bus_rdata >> {addr_lo_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_ext = {24'h0, lane[7:0]};
      3'b101:  ld_ext = {16'h0, lane[15:0]};
      default: ld_ext = lane;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    ld_data_d   = ld_data_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;

    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (illegal || misaligned) begin
            state_d = FAULT;
          end else begin
            state_d     = REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            bus_be_d    = mem_write ? st_be : 4'b1111;
            bus_wdata_d = mem_write ? st_wdata : 32'h0;
            funct3_d    = funct3;
            addr_lo_d   = addr[1:0];
          end
        end
      end
      REQ: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = DONE;
          if (!bus_we_q) ld_data_d = ld_ext;
        end
`ifdef LSU_TIMEOUT_EN
        else if (timed_out) begin
          bus_req_d = 1'b0;
          state_d   = FAULT;
        end
`endif
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0;
      ld_data_q   <= 32'h0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      ld_data_q   <= ld_data_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
    end
  end

  // Combinational so the pipeline advances in the very DONE/FAULT cycle.
  assign stall     = (mem_read | mem_write) & (state_q != DONE) & (state_q != FAULT);
  assign ld_valid  = (state_q == DONE) & ~bus_we_q;
  assign lsu_fault = (state_q == FAULT);
  assign ld_data   = ld_data_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized self-checking bench for lsu_ctrl against a behavioural load/store reference model.
module tb_lsu_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, ld_valid, lsu_fault, bus_req, bus_we, bus_ack;
  logic [31:0] ld_data, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] lastLoad = 32'h0;

  lsu_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
    .ld_data(ld_data), .ld_valid(ld_valid), .lsu_fault(lsu_fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: access size in bytes drives alignment, enables, lane replication and extension.
  function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                                output bit fault, output logic [3:0] be,
                                output logic [31:0] bwd, output logic [31:0] ld);
    int size, off;
    logic [31:0] sh, mask;
    size  = 1 << f3[1:0];
    off   = int'(a % 4);
    fault = 1'b0;
    if (rd && wr) fault = 1'b1;
    else if (rd)  fault = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else          fault = !(f3 inside {3'd0, 3'd1, 3'd2});
    if (!fault && (int'(a % 32'(size)) != 0)) fault = 1'b1;
    be = 4'hF; bwd = 32'h0; ld = 32'h0;
    if (fault) return;
    if (wr) begin
      be = 4'((32'(1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) bwd[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    sh = rw >> (8 * off);
    if (size == 4) ld = sh;
    else begin
      mask = (32'h1 << (8 * size)) - 1;
      ld = sh & mask;
      if (!f3[2] && ld[8*size-1]) ld = ld | ~mask;
    end
  endfunction

  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rword, input int delay, input string name);
    bit fault; logic [3:0] be; logic [31:0] bwd, ld;
    model(rd, wr, f3, a, wd, rword, fault, be, bwd, ld);
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    #1;
    vectors++;
    if ({stall, bus_req} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL %s req-cycle stall/bus_req got %b exp 10", name, {stall, bus_req});
    end
    if (fault) begin
      @(negedge clk);
      vectors++;
      if ({bus_req, stall, ld_valid, lsu_fault, ld_data} !== {4'b0001, lastLoad}) begin
        miscompares++;
        $display("[TB] FAIL %s fault-cycle req/stall/vld/flt,ld got %b,%h exp 0001,%h",
                 name, {bus_req, stall, ld_valid, lsu_fault}, ld_data, lastLoad);
      end
    end else begin
      for (int k = 0; k <= delay; k++) begin
        @(negedge clk);
        bus_ack   = (k == delay);
        bus_rdata = (k == delay) ? rword : $urandom;
        funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        vectors++;
        if ({bus_req, bus_we, bus_be, bus_addr, stall, ld_valid, lsu_fault} !==
            {1'b1, wr, be, a & 32'hFFFF_FFFC, 3'b100}) begin
          miscompares++;
          $display("[TB] FAIL %s req cyc%0d req/we/be/addr/stall/vld/flt got %b/%b/%b/%h/%b exp 1/%b/%b/%h/100",
                   name, k, bus_req, bus_we, bus_be, bus_addr, {stall, ld_valid, lsu_fault},
                   wr, be, a & 32'hFFFF_FFFC);
        end
        if (wr) begin
          vectors++;
          if (bus_wdata !== bwd) begin
            miscompares++;
            $display("[TB] FAIL %s bus_wdata got %h exp %h", name, bus_wdata, bwd);
          end
        end
      end
      @(negedge clk);
      bus_ack = 1'b0;
      if (rd) lastLoad = ld;
      vectors++;
      if ({bus_req, stall, ld_valid, lsu_fault, ld_data} !== {2'b00, rd, 1'b0, lastLoad}) begin
        miscompares++;
        $display("[TB] FAIL %s done req/stall/vld/flt,ld got %b,%h exp 00%b0,%h",
                 name, {bus_req, stall, ld_valid, lsu_fault}, ld_data, rd, lastLoad);
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
    bus_ack = 0; bus_rdata = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, ld_data, ld_valid, lsu_fault, stall} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset outputs got req%b we%b be%b addr%h wd%h ld%h v%b f%b s%b exp all 0",
               bus_req, bus_we, bus_be, bus_addr, bus_wdata, ld_data, ld_valid, lsu_fault, stall);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_access(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, "lb_1003");
    vectors++;
    if (ld_data !== 32'hFFFF_FF80) begin
      miscompares++;
      $display("[TB] FAIL lb_value got %h exp ffffff80", ld_data);
    end
    run_access(1, 0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 3, "lhu_2002");
    vectors++;
    if (ld_data !== 32'h0000_BEEF) begin
      miscompares++;
      $display("[TB] FAIL lhu_value got %h exp 0000beef", ld_data);
    end
    run_access(0, 1, 3'b000, 32'h11, 32'h0000_00A5, 32'h0, 0, "sb_11");
    run_access(0, 1, 3'b001, 32'h12, 32'h0000_1234, 32'h0, 1, "sh_12");
    run_access(1, 0, 3'b010, 32'h6, 32'h0, 32'h0, 0, "lw_misaligned");
    run_access(1, 0, 3'b011, 32'h40, 32'h0, 32'h0, 0, "load_f3_011");
    run_access(1, 1, 3'b010, 32'h40, 32'h0, 32'h0, 0, "read_and_write");
    run_access(0, 1, 3'b100, 32'h40, 32'h0, 32'h0, 0, "store_f3_100");
  endtask

  task automatic test_ack_outside_req();
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus_req, ld_valid, lsu_fault, ld_data} !== {3'b000, lastLoad}) begin
      miscompares++;
      $display("[TB] FAIL idle_ack req/vld/flt,ld got %b,%h exp 000,%h",
               {bus_req, ld_valid, lsu_fault}, ld_data, lastLoad);
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    mem_read = 1; funct3 = 3'b010; addr = 32'h200;
    @(negedge clk);
    vectors++;
    if (bus_req !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrst_pre bus_req got %b exp 1", bus_req);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, ld_data, ld_valid, lsu_fault} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midrst outputs got req%b be%b addr%h ld%h exp all 0",
               bus_req, bus_be, bus_addr, ld_data);
    end
    lastLoad = 32'h0;
    mem_read = 0;
    @(negedge clk);
    rst = 1'b0;
    run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, "lw_after_rst");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 80; n++) begin
      int r;
      logic rd, wr;
      logic [31:0] a;
      r  = int'($urandom_range(0, 9));
      rd = (r <= 4);
      wr = (r == 0) || (r >= 5);
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      run_access(rd, wr, 3'($urandom), a, $urandom, $urandom, int'($urandom_range(0, 3)), "random");
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    mem_read = 1; funct3 = 3'b010; addr = 32'h300;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      vectors++;
      if ({bus_req, lsu_fault} !== 2'b10) begin
        miscompares++;
        $display("[TB] FAIL timeout_wait cyc%0d req/flt got %b exp 10", k, {bus_req, lsu_fault});
      end
    end
    @(negedge clk);
    vectors++;
    if ({bus_req, ld_valid, lsu_fault} !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL timeout_fault req/vld/flt got %b exp 001", {bus_req, ld_valid, lsu_fault});
    end
    mem_read = 0;
    @(negedge clk);
    vectors++;
    if ({bus_req, lsu_fault} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL timeout_idle req/flt got %b exp 00", {bus_req, lsu_fault});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_ack_outside_req();
    test_reset_mid_req();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
